// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main controller: state encodings, opcodes and select codes.
// Build option: MC_CTRL_ADDI_EN adds addi support (ADDI_EX/ADDI_WB states).
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_RWB     = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_JUMP    = 4'd9;
    localparam logic [3:0] ST_ADDI_EX = 4'd10;
    localparam logic [3:0] ST_ADDI_WB = 4'd11;
    localparam logic [3:0] ST_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Successor of DECODE for a given opcode.
    function automatic logic [3:0] decode_next(input logic [5:0] op);
        logic [3:0] nxt;
        case (op)
            OP_LW, OP_SW: nxt = ST_MEMADR;
            OP_RTYPE:     nxt = ST_EXEC;
            OP_BEQ:       nxt = ST_BRANCH;
            OP_J:         nxt = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      nxt = ST_ADDI_EX;
`endif
            default:      nxt = ST_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of controller state (and mem_ready in FETCH) into datapath controls.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_illegal_op
);

    // Per-state control decode; unused encodings keep every strobe low.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_REG;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        o_illegal_op    = 1'b0;
        case (i_state)
            ST_FETCH: begin
                o_mem_read  = 1'b1;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
                o_alu_src_b = SRCB_FOUR;
            end
            ST_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEMADR, ST_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            ST_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            ST_ADDI_WB: begin
                o_reg_write = 1'b1;
            end
`endif
            ST_ILLEGAL: begin
                o_illegal_op = 1'b1;
            end
            default: begin
                o_illegal_op = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register and next-state logic; outputs via mc_ctrl_outdec.
// Build option: MC_CTRL_ADDI_EN enables the addi path.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       r_is_store;

    // Next-state selection; MEMADR uses the load/store flag captured in DECODE.
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:   w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:  w_next_state = decode_next(opcode);
            ST_MEMADR:  w_next_state = r_is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   w_next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:   w_next_state = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:    w_next_state = ST_RWB;
`ifdef MC_CTRL_ADDI_EN
            ST_ADDI_EX: w_next_state = ST_ADDI_WB;
`endif
            default:    w_next_state = ST_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture store-vs-load while the opcode is valid, so later opcode changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_store <= (opcode == OP_SW);
        end else begin
            r_is_store <= r_is_store;
        end
    end

    assign state = r_state;

    mc_ctrl_outdec u_outdec (
        .i_state         (r_state),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (PCWrite),
        .o_pc_write_cond (PCWriteCond),
        .o_iord          (IorD),
        .o_mem_read      (MemRead),
        .o_mem_write     (MemWrite),
        .o_ir_write      (IRWrite),
        .o_mem_to_reg    (MemtoReg),
        .o_reg_dst       (RegDst),
        .o_reg_write     (RegWrite),
        .o_alu_src_a     (ALUSrcA),
        .o_alu_src_b     (ALUSrcB),
        .o_alu_op        (ALUOp),
        .o_pc_source     (PCSource),
        .o_illegal_op    (illegal_op)
    );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory access and write-back across several clock cycles, and drives every datapath enable and mux select. Produces the 2-bit `ALUOp` consumed by `ALU_control`: 00 add, 01 subtract, 10 funct-decoded. Sits between the instruction register opcode field and the shared datapath: PC, memory port, register file and ALU.

## Interface
Parameters:
- none; opcode and state constants come from the shared package.

Ports:
- `clk` in 1: single system clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], sampled in DECODE.
- `mem_ready` in 1: memory handshake; access completes in a cycle where it is 1.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load if ALU zero.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1, `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write-data select; 1 = MDR.
- `RegDst` out 1: destination select; 1 = rd.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2.
- `ALUOp` out 2: to `ALU_control`.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000, only with the configuration macro defined.
- States and encodings:
  - FETCH 0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are both equal to mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, j → JUMP, addi → ADDI_EX, anything else → ILLEGAL.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
  - MEMRD 3: MemRead=1, IorD=1. Hold until mem_ready, then → MEMWB.
  - MEMWB 4: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
  - MEMWR 5: MemWrite=1, IorD=1. Hold until mem_ready, then → FETCH.
  - EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → RWB.
  - RWB 7: RegWrite=1, RegDst=1, MemtoReg=0. → FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
  - JUMP 9: PCWrite=1, PCSource=10. → FETCH.
  - ADDI_EX 10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. → ADDI_WB.
  - ADDI_WB 11: RegWrite=1, RegDst=0, MemtoReg=0. → FETCH.
  - ILLEGAL 12: illegal_op=1, no writes. → FETCH; the PC has already advanced by 4.
- Any output not listed for a state is 0.
- Unused encodings 13–15 return to FETCH on the next edge, with all strobes 0.
- MemRead and MemWrite are never both 1. RegWrite, PCWrite and MemWrite are never asserted outside the states listed above.

## Timing
- State register updates on the rising edge of `clk`; `rst_n` low forces FETCH immediately, asynchronously.
- Outputs are combinational from `state`, plus `mem_ready` in FETCH only.
- Reset values, since FETCH is state 0:
  - MemRead=1, ALUSrcB=01, state=0.
  - IRWrite and PCWrite follow mem_ready.
  - All other outputs 0.
- Cycles per instruction with mem_ready held at 1: j 3, beq 3, R-type 4, sw 4, addi 4, lw 5, illegal 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle; no upper bound.
- Reset asserted mid-instruction abandons the instruction; no partial write-back is issued after rst_n rises.
- The opcode is sampled only in DECODE; changes in other states are ignored.

## Configuration
- `MC_CTRL_ADDI_EN` defined: addi decodes to ADDI_EX → ADDI_WB.
- Undefined: the ADDI states are absent, and opcode 001000 goes to ILLEGAL with an illegal_op pulse.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings (localparams, 4 bits)
  - opcode constants
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - ALUSrcB and PCSource select constants
- Sub-module `mc_ctrl_outdec`: purely combinational state/mem_ready → control-signal decode. The top level keeps the state register and next-state logic.

## Test plan
- Reset, then lw with mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 in cycle 5 only.
- R-type: states 0,1,6,7,0. ALUOp=10 in EXEC; RegDst=1 and RegWrite=1 in RWB.
- beq: state 8 shows ALUOp=01, PCWriteCond=1, PCSource=01. j: state 9 shows PCWrite=1, PCSource=10. Both take 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, then FETCH. Same stall in FETCH gives IRWrite=0 until mem_ready=1.
- Opcode 111111: ILLEGAL for 1 cycle with illegal_op=1, then FETCH. Opcode 001000 gives ILLEGAL without `MC_CTRL_ADDI_EN`, and states 10,11 with it.
- rst_n pulsed low in MEMRD: state=0 asynchronously, and no RegWrite occurs afterward for that instruction.
